seg7_multi_display: RTL
=======================

// Module: seg7_multi_display
// PURPOSE
//  Parametrised N-digit seven-segment driver for the board top level; replaces per-digit decoder wiring.
//  Latches a binary value on LOAD and shows it on HEX digits in hex or decimal.
//  Decimal uses a sequential double-dabble converter with a BUSY/DONE handshake.
//  Adds leading-zero blanking, overflow dashes and per-digit blinking.
// PARAMETERS
//  NUM_DIGITS  6           number of digits driven (HEX0..HEX[NUM_DIGITS-1])
//  BIN_W       20          width of VALUE; constraint: BIN_W <= 4*NUM_DIGITS
//  BLINK_DIV   25_000_000  CLOCK cycles per blink half-period; >= 1
// PORTS
//  CLOCK       in   1             system clock; all state on rising edge
//  RESET       in   1             synchronous, active-high reset
//  VALUE       in   BIN_W         unsigned binary value, sampled with LOAD
//  MODE        in   1             0 = hex, 1 = decimal; sampled with LOAD
//  LOAD        in   1             start strobe; honoured only when BUSY=0
//  BLANK_LZ    in   1             1 = blank leading zero digits (live, not latched)
//  BLINK_MASK  in   NUM_DIGITS    bit i = 1: digit i blinks (live, not latched)
//  BUSY        out  1             high from the cycle after LOAD is accepted until commit
//  DONE        out  1             one-cycle pulse in the cycle after commit
//  OVERFLOW    out  1             last committed decimal value >= 10**NUM_DIGITS
//  HEX         out  7*NUM_DIGITS  active-low segments; digit i at [7i+6:7i], bit order {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset: state IDLE; BUSY=0, DONE=0, OVERFLOW=0; valid=0, so HEX is all 1s (blank);
//   blink counter=0, phase=1 (on). RESET overrides LOAD in the same cycle.
//  FSM: IDLE, CONVERT, COMMIT. BUSY = (state != IDLE).
//   IDLE, LOAD=1, MODE=0: capture VALUE, go to COMMIT.
//   IDLE, LOAD=1, MODE=1: load shift register {BCD=0, VALUE}, clear iteration count,
//    set ovf_pending = (VALUE >= 10**NUM_DIGITS), go to CONVERT.
//   CONVERT: each cycle add 3 to every BCD nibble >= 5, then shift left 1.
//    After exactly BIN_W iterations go to COMMIT.
//   COMMIT: write display register, set valid=1, set OVERFLOW (MODE=0: always 0),
//    DONE=1 next cycle, go to IDLE.
//  LOAD while BUSY=1 is ignored; it is not queued.
//  Latency, with the accepting edge as edge 0:
//   hex: commit at edge 1; BUSY high 1 cycle.
//   decimal: commit at edge BIN_W+1 (21 at defaults); BUSY high BIN_W+1 cycles.
//  HEX is combinational from registered state and the live inputs BLANK_LZ and BLINK_MASK.
//   It updates in the cycle after the commit edge. It holds the old value while BUSY=1.
//  Hex mode: digit i = VALUE[4i+3:4i]; digits beyond BIN_W are 0.
//   Glyphs 0-9, A, b, C, d, E, F; '8' is all segments lit.
//  Leading zeros: with BLANK_LZ=1, every zero digit above the highest nonzero digit is blank.
//   Digit 0 is never blanked.
//  Overflow: all digits show a dash (7'b0111111). BLANK_LZ does not apply. BLINK_MASK does apply.
//  Blink: counter counts 0..BLINK_DIV-1, then wraps and toggles phase; runs continuously from reset.
//   A masked digit is blank while phase=0.
//  Reset during CONVERT or COMMIT: the conversion is aborted, FSM returns to IDLE, valid=0 (blank), DONE not asserted.
//  Back-to-back: a LOAD in the DONE cycle is accepted (BUSY is already 0 then).
// STRUCTURE
//  Shared package seg7_pkg:
//   SEG_BLANK = 7'h7F, SEG_DASH = 7'b0111111
//   16-entry glyph table (active-low)
//   FSM state encoding
//   pow10 constant function, used for the overflow threshold
//  Sub-module seg7_decode (4-bit digit -> 7-bit active-low glyph):
//   instantiated NUM_DIGITS times in a generate loop.
//  Digit blanking and blink muxing sit outside seg7_decode, in this block.
// TESTING (defaults unless stated; HEX listed digit5..digit0)
//  1 Reset: assert RESET 2 cycles -> HEX all 1s, BUSY=0, DONE=0, OVERFLOW=0.
//    Repeat with LOAD=1 held during RESET -> no commit.
//  2 Hex mode: MODE=0, VALUE=20'hA5F3C, LOAD 1 cycle, BLANK_LZ=0
//    -> BUSY=1 for 1 cycle, DONE pulse, HEX shows 0 A 5 F 3 C.
//    Then BLANK_LZ=1 -> digit5 blank, others unchanged.
//  3 Decimal: MODE=1, VALUE=123456 -> BUSY=1 for 21 cycles, DONE pulse in cycle 22,
//    HEX shows 1 2 3 4 5 6, OVERFLOW=0.
//    Then VALUE=7, BLANK_LZ=1 -> digits 5..1 blank, digit0 shows 7.
//  4 Overflow: MODE=1, VALUE=1000000 -> OVERFLOW=1, all digits show dash.
//    Then VALUE=999999 -> OVERFLOW=0, shows 9 9 9 9 9 9.
//  5 Handshake:
//    a) LOAD VALUE=42, then LOAD VALUE=99 at cycle 5 while BUSY=1 -> only 42 shown, single DONE.
//    b) Reset at cycle 10 of a conversion -> blank, no DONE; next LOAD converts normally.
//  6 Blink: BLINK_DIV=4, BLINK_MASK=6'b000001, shown value 5
//    -> digit0 alternates glyph/blank every 4 cycles; other digits steady; mask=0 stops blinking.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display slice: glyphs, FSM encoding, decimal limits.
// No logic here; latency and backpressure are properties of the modules that import it.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}; entry 15 first because this is a packed array.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/seg7_multi_display_if.sv
// Load/status/segment bundle between the board top and the display driver.
// master drives VALUE/MODE/LOAD and the live display controls; slave returns BUSY/DONE/OVERFLOW/HEX.
interface seg7_multi_display_if #(
  parameter int NUM_DIGITS = 6,
  parameter int BIN_W      = 20
);
  logic [BIN_W-1:0]        VALUE;
  logic                    MODE;
  logic                    LOAD;
  logic                    BLANK_LZ;
  logic [NUM_DIGITS-1:0]   BLINK_MASK;
  logic                    BUSY;
  logic                    DONE;
  logic                    OVERFLOW;
  logic [7*NUM_DIGITS-1:0] HEX;

  modport master (
    output VALUE, MODE, LOAD, BLANK_LZ, BLINK_MASK,
    input  BUSY, DONE, OVERFLOW, HEX
  );

  modport slave (
    input  VALUE, MODE, LOAD, BLANK_LZ, BLINK_MASK,
    output BUSY, DONE, OVERFLOW, HEX
  );
endinterface

// File: rtl/seg7_decode.sv
// 4-bit digit to active-low seven-segment glyph; purely combinational, zero latency.
// No handshake: the output follows the input every cycle.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  assign seg = GLYPH_TABLE[digit];
endmodule

// File: rtl/seg7_multi_display.sv
// N-digit hex/decimal seven-segment driver; commit 1 cycle after LOAD (hex) or BIN_W+1 (decimal).
// LOAD is accepted only while BUSY=0 and is dropped, not queued, otherwise.
module seg7_multi_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BIN_W      = 20,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  seg7_multi_display_if.slave  bus
);

  localparam int          DW      = 4 * NUM_DIGITS;
  localparam int          SW      = DW + BIN_W;
  localparam int          IW      = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int          CW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [63:0] OVF_LIM = pow10(NUM_DIGITS);

  state_t                      state, state_nxt;
  logic   [SW-1:0]             sr, sr_adj;
  logic   [IW-1:0]             iter;
  logic                        mode_q, ovf_pending;
  logic   [DW-1:0]             disp;
  logic                        valid, ovf, done;
  logic   [CW-1:0]             blink_cnt;
  logic                        phase;
  logic   [NUM_DIGITS-1:0][6:0] glyph, hex_seg;
  logic   [NUM_DIGITS-1:0]     lz;
  logic                        zero_run;

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.LOAD) state_nxt = bus.MODE ? ST_CONVERT : ST_COMMIT;
      ST_CONVERT: if (iter == IW'(BIN_W - 1)) state_nxt = ST_COMMIT;
      ST_COMMIT:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sr[BIN_W + 4*i +: 4] >= 4'd5)
        sr_adj[BIN_W + 4*i +: 4] = sr[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sr          <= '0;
      iter        <= '0;
      mode_q      <= 1'b0;
      ovf_pending <= 1'b0;
      disp        <= '0;
      valid       <= 1'b0;
      ovf         <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.LOAD) begin
            sr          <= SW'(bus.VALUE);
            mode_q      <= bus.MODE;
            iter        <= '0;
            ovf_pending <= bus.MODE && (64'(bus.VALUE) >= OVF_LIM);
          end
        end
        ST_CONVERT: begin
          sr   <= sr_adj << 1;
          iter <= iter + IW'(1);
        end
        ST_COMMIT: begin
          disp  <= mode_q ? sr[SW-1 -: DW] : DW'(sr[BIN_W-1:0]);
          valid <= 1'b1;
          ovf   <= mode_q & ovf_pending;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + CW'(1);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .digit (disp[4*g +: 4]),
      .seg   (glyph[g])
    );
  end

  // lz[i]: digit i and every digit above it are zero.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (disp[4*i +: 4] == 4'd0);
      lz[i]    = zero_run;
    end
  end

  always_comb begin
    hex_seg = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!valid)                                hex_seg[i] = SEG_BLANK;
      else if (ovf)                              hex_seg[i] = SEG_DASH;
      else if (bus.BLANK_LZ && lz[i] && (i != 0)) hex_seg[i] = SEG_BLANK;
      else                                       hex_seg[i] = glyph[i];
      if (bus.BLINK_MASK[i] && !phase)           hex_seg[i] = SEG_BLANK;
    end
  end

  assign bus.HEX      = hex_seg;
  assign bus.BUSY     = (state != ST_IDLE);
  assign bus.DONE     = done;
  assign bus.OVERFLOW = ovf;

endmodule
